de0_sweep_ctrl: RTL and testbench
=================================

DE0_SWEEP_CTRL -- requirements
Module: de0_sweep_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning datapath latency in clocks from sel/din_0/din_1 driven to dout valid (legal range 1..4).
REQ-002 SHALL have parameter D_SIZE, default 2, meaning the datapath parameter value, passed through unchanged and unused internally.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a sweep request sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1, which terminates a sweep.
REQ-007 SHALL have port mode_mask, input, 4, where bit k enables the sweep of sel=k.
REQ-008 SHALL have port sel, output, 2, the datapath operation select.
REQ-009 SHALL have ports din_0 and din_1, output, 4 each, the datapath operands.
REQ-010 SHALL have port dout_in, input, 4, the datapath result.
REQ-011 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-012 SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-013 SHALL have port checksum, output, 8, the sum of captured results modulo 256.
REQ-014 SHALL have port vec_cnt, output, 10, the number of results captured in the current or last sweep.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL, in IDLE with start=1, clear checksum and vec_cnt, select the lowest enabled mode, and enter RUN; if mode_mask=0 it SHALL enter DONE directly.
REQ-017 SHALL drive exactly one new vector per cycle in RUN, with no gaps.
REQ-018 SHALL use these sequences per enabled mode, visited in ascending sel order, with disabled modes skipped at zero cycle cost:
- sel=0: din_0 = 0..15, din_1 = 0 (16 vectors).
- sel=1: din_0 = 0, din_1 = 0..15 (16 vectors).
- sel=2 and sel=3: din_0 = 0..15 outer, din_1 = 0..15 inner (256 vectors each).
REQ-019 SHALL capture dout_in exactly LAT cycles after each vector is driven, using a LAT-deep valid shift pipeline, and add it zero-extended to checksum, wrapping modulo 256.
REQ-020 SHALL increment vec_cnt by 1 for each captured vector.
REQ-021 SHALL, after the last vector of the last enabled mode is driven, enter DRAIN for LAT cycles, then DONE.
REQ-022 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-023 SHALL hold checksum and vec_cnt stable from DONE until the next accepted start.
REQ-024 SHALL drive sel=0, din_0=0 and din_1=0 in IDLE, DRAIN and DONE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort=1 in RUN or DRAIN, go to IDLE on the next edge, flush the valid pipeline, and not assert done; checksum and vec_cnt keep their partial values.
REQ-027 SHALL give abort priority over a capture scheduled in the same cycle, so that capture is dropped.
REQ-028 SHALL treat abort as having no effect in IDLE and DONE.
REQ-029 SHALL sample mode_mask only when start is accepted; later changes have no effect on the current sweep.
REQ-030 SHALL make the start-to-done latency equal to N+LAT+1 cycles, where N is the total enabled vector count.

Reset
REQ-031 SHALL, while n_rst=0, force state to IDLE and all outputs to 0, and clear all counters and the valid pipeline, independent of clk.
REQ-032 SHALL abandon any sweep in progress when reset is asserted mid-sweep, with no done pulse.

Structure
REQ-033 SHALL place the state encoding, the per-mode vector counts (16, 16, 256, 256) and the widths (4, 8, 10) in shared package de0_training_pkg.
REQ-034 SHALL contain one sub-module, de0_vec_gen, an operand/mode counter that emits sel, din_0, din_1 and a last flag; the FSM, capture pipeline and accumulator stay in the top level.

Verification
REQ-035 SHALL be verified with LAT=1 and a stub datapath in which sel0 returns din_0, sel1 returns din_1, sel2 returns (din_0+din_1) mod 16, and sel3 returns din_0 AND din_1.
REQ-036 SHALL pass this scenario: mode_mask=0001 -> checksum 0x78, vec_cnt 16, done 18 cycles after start.
REQ-037 SHALL pass this scenario: mode_mask=1111 -> checksum 0x30, vec_cnt 544, done 546 cycles after start, sel sequence 0,1,2,3.
REQ-038 SHALL pass this scenario: mode_mask=1100 -> checksum 0x40, vec_cnt 512, with no sel=0 or sel=1 cycles observed.
REQ-039 SHALL pass this scenario: mode_mask=0000 -> done on the cycle after start, checksum 0, vec_cnt 0, busy never high.
REQ-040 SHALL pass this scenario: abort pulsed in RUN at vector 40 with mask 1111 -> no done, IDLE next cycle, vec_cnt 39, outputs zero, and a subsequent start with mask 0010 gives checksum 0x78.
REQ-041 SHALL pass this scenario: n_rst asserted mid-sweep, and start pulses applied while busy -> all outputs are 0 immediately on reset, and the start pulses while busy are ignored.

Source files
------------

// File: rtl/de0_sweep_ctrl_pkg.sv
// Shared types, widths and mode tables for the sweep controller.
// Mode k enumerates VEC_CNT[k] operand vectors.
package de0_training_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int OPW   = 4;
  localparam int CSW   = 8;
  localparam int CNTW  = 10;
  localparam int NMODE = 4;

  localparam int unsigned VEC_CNT [NMODE] =
    '{16, 16, 256, 256};

  function automatic logic [7:0] mode_last(
    input logic [1:0] s
  );
    return 8'(VEC_CNT[s] - 1);
  endfunction

  // Lowest enabled mode >= from; bit 2 set means none.
  function automatic logic [2:0] find_mode(
    input logic [3:0] m,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'b100;
    for (int k = NMODE - 1; k >= 0; k--) begin
      if (m[k] && (3'(k) >= from)) begin
        r = 3'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/de0_sweep_ctrl_if.sv
// Control bus between the sweep FSM and the vector
// generator: load/advance in, operands and last flag out.
interface de0_sweep_ctrl_if;
  import de0_training_pkg::*;

  logic           load;
  logic           adv;
  logic [3:0]     mask;
  logic [1:0]     sel;
  logic [OPW-1:0] din_0;
  logic [OPW-1:0] din_1;
  logic           last;

  modport ctrl (
    output load, adv, mask,
    input  sel, din_0, din_1, last
  );

  modport gen (
    input  load, adv, mask,
    output sel, din_0, din_1, last
  );

endinterface

// File: rtl/de0_vec_gen.sv
// Operand/mode counter: walks enabled modes in ascending
// order and flags the final vector of the sweep.
module de0_vec_gen
  import de0_training_pkg::*;
(
  input logic          clk,
  input logic          n_rst,
  de0_sweep_ctrl_if.gen vg
);

  logic [3:0] mask_q, mask_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] idx_q, idx_d;
  logic       mode_end;
  logic [2:0] nxt;
  logic [2:0] first;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mask_q <= '0;
      sel_q  <= '0;
      idx_q  <= '0;
    end else begin
      mask_q <= mask_d;
      sel_q  <= sel_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    mask_d   = mask_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    mode_end = (idx_q == mode_last(sel_q));
    nxt      = find_mode(mask_q, {1'b0, sel_q} + 3'd1);
    first    = find_mode(vg.mask, 3'd0);
    if (vg.load) begin
      mask_d = vg.mask;
      sel_d  = first[1:0];
      idx_d  = '0;
    end else if (vg.adv) begin
      if (mode_end) begin
        idx_d = '0;
        if (!nxt[2]) begin
          sel_d = nxt[1:0];
        end
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
  end

  always_comb begin
    vg.sel   = sel_q;
    vg.last  = mode_end && nxt[2];
    vg.din_0 = '0;
    vg.din_1 = '0;
    unique case (sel_q)
      2'd0: vg.din_0 = idx_q[3:0];
      2'd1: vg.din_1 = idx_q[3:0];
      default: begin
        vg.din_0 = idx_q[7:4];
        vg.din_1 = idx_q[3:0];
      end
    endcase
  end

endmodule

// File: rtl/de0_sweep_ctrl.sv
// Datapath sweep controller: drives operand vectors,
// captures results after LAT clocks and accumulates them.
module de0_sweep_ctrl
  import de0_training_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int D_SIZE = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      mode_mask,
  output logic [1:0]      sel,
  output logic [OPW-1:0]  din_0,
  output logic [OPW-1:0]  din_1,
  input  logic [OPW-1:0]  dout_in,
  output logic            busy,
  output logic            done,
  output logic [CSW-1:0]  checksum,
  output logic [CNTW-1:0] vec_cnt
);

  state_e          state_q, state_d;
  logic [1:0]      drn_q, drn_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [CSW-1:0]  cs_q, cs_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            load, adv, kill, cap;
  logic            run;

  de0_sweep_ctrl_if vg ();

  assign vg.load = load;
  assign vg.adv  = adv;
  assign vg.mask = mode_mask;

  de0_vec_gen u_gen (
    .clk   (clk),
    .n_rst (n_rst),
    .vg    (vg.gen)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      drn_q   <= '0;
      vld_q   <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      vld_q   <= vld_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drn_d   = drn_q;
    load    = 1'b0;
    adv     = 1'b0;
    kill    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (mode_mask == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else begin
          adv = 1'b1;
          if (vg.last) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else if (drn_q == 2'(LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abort flushes the pipe and wins over a same-cycle capture.
  always_comb begin
    cap   = vld_q[LAT-1] && !kill;
    vld_d = kill ? '0 : LAT'({vld_q, adv});
    cs_d  = cs_q;
    cnt_d = cnt_q;
    if (load) begin
      cs_d  = '0;
      cnt_d = '0;
    end else if (cap) begin
      cs_d  = cs_q + CSW'(dout_in);
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  assign run      = (state_q == S_RUN);
  assign busy     = run || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign sel      = run ? vg.sel   : '0;
  assign din_0    = run ? vg.din_0 : '0;
  assign din_1    = run ? vg.din_1 : '0;
  assign checksum = cs_q;
  assign vec_cnt  = cnt_q;

endmodule

// File: tb/tb_de0_sweep_ctrl.sv
// Directed bench for de0_sweep_ctrl with LAT=1 and a
// registered stub datapath.
module tb_de0_sweep_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic [3:0] dout;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [9:0] vec_cnt;

  int n_pass = 0;
  int n_chk  = 0;
  int sc [4];
  int sf [4];
  logic bsy;
  int lat;
  int cnt;

  de0_sweep_ctrl_if dp ();

  assign dp.load = 1'b0;
  assign dp.adv  = 1'b0;
  assign dp.last = 1'b0;

  always #5 clk = ~clk;

  de0_sweep_ctrl #(.LAT(1), .D_SIZE(2)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .mode_mask (dp.mask),
    .sel       (dp.sel),
    .din_0     (dp.din_0),
    .din_1     (dp.din_1),
    .dout_in   (dout),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .vec_cnt   (vec_cnt)
  );

  always @(posedge clk) begin
    case (dp.sel)
      2'd0:    dout <= dp.din_0;
      2'd1:    dout <= dp.din_1;
      2'd2:    dout <= dp.din_0 + dp.din_1;
      default: dout <= dp.din_0 & dp.din_1;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic sweep(input logic [3:0] m,
                       input logic [3:0] m_after,
                       input int pulse_at,
                       output int l);
    for (int k = 0; k < 4; k++) begin
      sc[k] = 0;
      sf[k] = -1;
    end
    bsy = 1'b0;
    @(negedge clk);
    dp.mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    dp.mask = m_after;
    l = -1;
    for (int n = 1; n <= 2000; n++) begin
      if (busy) begin
        bsy = 1'b1;
        sc[dp.sel] = sc[dp.sel] + 1;
        if (sf[dp.sel] < 0) sf[dp.sel] = n;
      end
      if (done) begin
        l = n;
        break;
      end
      start = (n == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    n_rst   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    dp.mask = 4'd0;
    #3;
    chk("reset_outs",
        {busy, done, dp.sel, dp.din_0, dp.din_1,
         checksum, vec_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // mask 0001; mask change after acceptance is ignored
    sweep(4'b0001, 4'b1111, 0, lat);
    chk("m1_lat", lat, 18);
    chk("m1_cs", checksum, 8'h78);
    chk("m1_cnt", vec_cnt, 16);
    chk("m1_sel1", sc[1], 0);
    @(negedge clk);
    chk("m1_done_1cyc", {done, busy}, 2'b00);

    // full mask, with a start pulse while busy
    sweep(4'b1111, 4'b0000, 100, lat);
    chk("mf_lat", lat, 546);
    chk("mf_cs", checksum, 8'h30);
    chk("mf_cnt", vec_cnt, 544);
    chk("mf_first1", sf[1], 17);
    chk("mf_first2", sf[2], 33);
    chk("mf_first3", sf[3], 289);
    chk("mf_n0", sc[0], 17);
    chk("mf_n1", sc[1], 16);
    chk("mf_n2", sc[2], 256);
    chk("mf_n3", sc[3], 256);
    repeat (5) @(negedge clk);
    chk("mf_hold", {checksum, vec_cnt},
        {8'h30, 10'd544});
    chk("mf_idle", {busy, done}, 2'b00);

    // upper modes only
    sweep(4'b1100, 4'b1100, 0, lat);
    chk("mu_lat", lat, 514);
    chk("mu_cs", checksum, 8'h40);
    chk("mu_cnt", vec_cnt, 512);
    chk("mu_n0_drain", sc[0], 1);
    chk("mu_n1", sc[1], 0);
    chk("mu_first2", sf[2], 1);
    chk("mu_first3", sf[3], 257);

    // empty mask
    sweep(4'b0000, 4'b0000, 0, lat);
    chk("mz_lat", lat, 1);
    chk("mz_busy", bsy, 1'b0);
    chk("mz_cs", checksum, 0);
    chk("mz_cnt", vec_cnt, 0);

    // abort at vector index 40 (sel2, din_0=0, din_1=8)
    @(negedge clk);
    dp.mask = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    for (int n = 1; n <= 200; n++) begin
      if (dp.sel == 2'd2 && dp.din_0 == 4'd0 &&
          dp.din_1 == 4'd8) begin
        cnt = n;
        break;
      end
      @(negedge clk);
    end
    chk("ab_found_at", cnt, 41);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle",
        {busy, done, dp.sel, dp.din_0, dp.din_1},
        12'd0);
    chk("ab_cnt", vec_cnt, 39);
    chk("ab_cs", checksum, 8'h05);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (done || busy) cnt = cnt + 1;
      @(negedge clk);
    end
    chk("ab_no_done", cnt, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle_abort", {busy, vec_cnt},
        {1'b0, 10'd39});

    sweep(4'b0010, 4'b0010, 0, lat);
    chk("ab_next_lat", lat, 18);
    chk("ab_next_cs", checksum, 8'h78);

    // reset mid-sweep, with start pulses while busy
    @(negedge clk);
    dp.mask = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      start = (n % 7 == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rs_cnt_pre", vec_cnt, 59);
    n_rst = 1'b0;
    #1;
    chk("rs_async",
        {busy, done, dp.sel, dp.din_0, dp.din_1,
         checksum, vec_cnt}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (done || busy) cnt = cnt + 1;
      @(negedge clk);
    end
    chk("rs_no_done", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
